// File: rtl/neureka_binconv_col_seq.sv
// neureka_binconv_col_seq
// Sequencer for one binconv column. For each output tile it walks the column
// through clear -> bit-serial MAC -> optional weight-offset beat -> drain ->
// done. Counters advance only on accepted activation beats, so block_cnt_o
// (and therefore the consumer's scale shift) is stable across every beat.
//
// Optional feature: define NEUREKA_BINCONV_SEQ_DW_EN to compile in the 3x3
// depthwise controls (invalidate_o / dw_weight_offset_o). Without it a DW
// filter mode is sequenced exactly like 3x3 and those outputs are tied off.
//
// filter_mode encoding: 0 = 3x3, 1 = 3x3 DW, 2 = 1x1.

module neureka_binconv_col_seq #(
  parameter int unsigned NEUREKA_COLUMN_SIZE = 9,
  parameter int unsigned COLUMN_SIZE         = NEUREKA_COLUMN_SIZE,
  parameter int unsigned N_BLOCKS            = 8,
  parameter int unsigned DRAIN_CYCLES        = 3,
  parameter int unsigned ITER_W              = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [1:0]                    filter_mode_i,
  input  logic [$clog2(N_BLOCKS):0]     qw_i,
  input  logic [ITER_W-1:0]             k_iter_i,
  input  logic                          woffs_en_i,
  input  logic [2:0]                    scale_shift_i,
  input  logic [COLUMN_SIZE-1:0]        enable_block_i,
  input  logic                          beat_fire_i,
  output logic                          clear_o,
  output logic                          enable_o,
  output logic [$clog2(N_BLOCKS)-1:0]   block_cnt_o,
  output logic                          weight_offset_o,
  output logic                          dw_weight_offset_o,
  output logic                          invalidate_o,
  output logic [1:0]                    filter_mode_o,
  output logic [2:0]                    scale_shift_o,
  output logic [COLUMN_SIZE-1:0]        enable_block_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned BW  = $clog2(N_BLOCKS);
  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [BW:0]       QW_ONE     = (BW+1)'(1);
  localparam logic [BW:0]       QW_MAX     = (BW+1)'(N_BLOCKS);
  localparam logic [ITER_W-1:0] ITER_ONE   = ITER_W'(1);
  localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] FM_3X3 = 2'd0;
  localparam logic [1:0] FM_DW  = 2'd1;
  localparam logic [1:0] FM_1X1 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_OFFSET,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [ITER_W-1:0] iter_cnt_q,  iter_cnt_d;
  logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
  logic              abort_clr_q;

  // latched tile configuration
  logic [1:0]             fmode_q;
  logic [BW-1:0]          qw_last_q;
  logic [ITER_W-1:0]      k_last_q;
  logic                   woffs_q;
  logic [2:0]             sshift_q;
  logic [COLUMN_SIZE-1:0] eblk_q;

  logic [BW:0]       qw_eff;
  logic [BW:0]       qw_m1;
  logic [BW-1:0]     qw_last_d;
  logic [ITER_W-1:0] k_last_d;
  logic              latch_cfg;

  // qw of 0 runs as 1; anything above the block count is clamped so the bit
  // counter can never run past the last block.
  always_comb begin
    qw_eff = qw_i;
    if (qw_i == '0)
      qw_eff = QW_ONE;
    else if (qw_i > QW_MAX)
      qw_eff = QW_MAX;
    qw_m1     = qw_eff - QW_ONE;
    qw_last_d = qw_m1[BW-1:0];
    k_last_d  = (k_iter_i == '0) ? '0 : (k_iter_i - ITER_ONE);
  end

  assign latch_cfg = (state_q == S_IDLE) && start_i && !abort_i;

  // next-state and counter logic; abort overrides every transition
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bit_cnt_d  = '0;
        iter_cnt_d = '0;
        state_d    = S_MAC;
      end
      S_MAC: begin
        if (beat_fire_i) begin
          if (bit_cnt_q == qw_last_q) begin
            bit_cnt_d = '0;
            if (iter_cnt_q == k_last_q) begin
              iter_cnt_d  = '0;
              drain_cnt_d = '0;
              state_d     = woffs_q ? S_OFFSET : S_DRAIN;
            end else begin
              iter_cnt_d = iter_cnt_q + ITER_ONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_OFFSET: begin
        if (beat_fire_i) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      iter_cnt_d  = '0;
      drain_cnt_d = '0;
    end
  end

  // state and counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      iter_cnt_q  <= '0;
      drain_cnt_q <= '0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      abort_clr_q <= abort_i;
    end
  end

  // configuration captured once per tile, held until the next accepted start
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fmode_q   <= '0;
      qw_last_q <= '0;
      k_last_q  <= '0;
      woffs_q   <= 1'b0;
      sshift_q  <= '0;
      eblk_q    <= '0;
    end else if (latch_cfg) begin
      fmode_q   <= filter_mode_i;
      qw_last_q <= qw_last_d;
      k_last_q  <= k_last_d;
      woffs_q   <= woffs_en_i;
      sshift_q  <= scale_shift_i;
      eblk_q    <= enable_block_i;
    end
  end

  // column controls decoded straight from registers; beat_fire_i never
  // reaches an output combinationally
  assign clear_o         = (state_q == S_CLEAR) || abort_clr_q;
  assign enable_o        = (state_q == S_MAC) || (state_q == S_OFFSET) ||
                           (state_q == S_DRAIN);
  assign block_cnt_o     = (state_q == S_MAC) ? bit_cnt_q : '0;
  assign weight_offset_o = (state_q == S_OFFSET);
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign filter_mode_o   = fmode_q;
  assign scale_shift_o   = sshift_q;
  assign enable_block_o  = eblk_q;

`ifdef NEUREKA_BINCONV_SEQ_DW_EN
  logic dw_mode;
  assign dw_mode = (fmode_q == FM_DW);
  // DW: hide popcount-valid outside the streaming window, and when an offset
  // beat follows, gate the MAC beats so only the offset beat contributes
  assign invalidate_o       = dw_mode && ((state_q == S_CLEAR) ||
                              (state_q == S_DRAIN) || (state_q == S_DONE));
  assign dw_weight_offset_o = !(dw_mode && woffs_q && (state_q == S_MAC));
`else
  assign invalidate_o       = 1'b0;
  assign dw_weight_offset_o = 1'b1;
`endif

  // mode constants kept for readers of the encoding; 3x3 and 1x1 need no
  // special sequencing here
  logic unused_fm;
  assign unused_fm = ^{FM_3X3, FM_1X1};

endmodule

// File: tb/tb_neureka_binconv_col_seq.sv
// Bench for neureka_binconv_col_seq: a beat-count/timestamp model of the tile
// predicts every output each cycle; directed tests add literal checks.
module tb_neureka_binconv_col_seq;
  localparam int CS = 4;
  localparam int NB = 8;
  localparam int DC = 3;
  localparam int IW = 16;
  localparam logic [1:0] FM3 = 2'd0, FMDW = 2'd1, FM1 = 2'd2;
`ifdef NEUREKA_BINCONV_SEQ_DW_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, abort, woffs, beat;
  logic [1:0] fm;
  logic [3:0] qw;
  logic [IW-1:0] kit;
  logic [2:0] ss;
  logic [CS-1:0] eb;
  logic clear_o, enable_o, weight_offset_o, dw_weight_offset_o, invalidate_o, busy_o, done_o;
  logic [2:0] block_cnt_o, scale_shift_o;
  logic [1:0] filter_mode_o;
  logic [CS-1:0] enable_block_o;

  always #5 clk = ~clk;

  neureka_binconv_col_seq #(.NEUREKA_COLUMN_SIZE(CS), .COLUMN_SIZE(CS), .N_BLOCKS(NB),
                            .DRAIN_CYCLES(DC), .ITER_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .filter_mode_i(fm), .qw_i(qw), .k_iter_i(kit), .woffs_en_i(woffs),
    .scale_shift_i(ss), .enable_block_i(eb), .beat_fire_i(beat),
    .clear_o(clear_o), .enable_o(enable_o), .block_cnt_o(block_cnt_o),
    .weight_offset_o(weight_offset_o), .dw_weight_offset_o(dw_weight_offset_o),
    .invalidate_o(invalidate_o), .filter_mode_o(filter_mode_o),
    .scale_shift_o(scale_shift_o), .enable_block_o(enable_block_o),
    .busy_o(busy_o), .done_o(done_o));

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---- model: a tile is B beats (qw*k MAC beats + optional offset beat);
  // time is measured from the start edge and from the last beat
  bit m_act, m_aclr, m_woffs;
  int m_rel, m_n, m_tlast, m_B, m_qw, m_k;
  logic [1:0] m_fm;
  logic [2:0] m_ss;
  logic [CS-1:0] m_eb;

  // 0 idle, 1 clear, 2 streaming beats, 3 drain, 4 done
  function automatic int phase();
    if (!m_act) return 0;
    if (m_rel == 1) return 1;
    if (m_tlast < 0) return 2;
    if (m_rel - m_tlast <= DC) return 3;
    return 4;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_aclr = 0; m_woffs = 0; m_fm = '0; m_ss = '0; m_eb = '0;
      m_rel = 0; m_n = 0; m_tlast = -1; m_B = 0; m_qw = 1; m_k = 1;
    end else if (abort) begin
      m_act = 0; m_aclr = 1;
    end else if (!m_act) begin
      m_aclr = 0;
      if (start) begin
        m_qw = (qw == 0) ? 1 : ((int'(qw) > NB) ? NB : int'(qw));
        m_k = (kit == 0) ? 1 : int'(kit);
        m_woffs = woffs; m_fm = fm; m_ss = ss; m_eb = eb;
        m_B = m_qw * m_k + (woffs ? 1 : 0);
        m_act = 1; m_rel = 1; m_n = 0; m_tlast = -1;
      end
    end else begin
      if (phase() == 2 && beat) begin
        m_n++;
        if (m_n == m_B) m_tlast = m_rel;
      end
      m_rel++;
      if (m_tlast >= 0 && m_rel - m_tlast == DC + 2) m_act = 0;
    end
  end

  // ---- per-cycle compare against the model
  always @(negedge clk) begin : cmp
    int ph;
    bit macph, dwm;
    if (chk_en) begin
      ph = phase();
      macph = (ph == 2) && (m_n < m_qw * m_k);
      dwm = DW_EN && (m_fm == FMDW);
      chk("clear", clear_o, (ph == 1) || m_aclr);
      chk("enable", enable_o, (ph == 2) || (ph == 3));
      chk("block_cnt", block_cnt_o, macph ? (m_n % m_qw) : 0);
      chk("weight_offset", weight_offset_o, (ph == 2) && !macph);
      chk("dw_weight_offset", dw_weight_offset_o, !(dwm && m_woffs && macph));
      chk("invalidate", invalidate_o, dwm && (ph == 1 || ph == 3 || ph == 4));
      chk("busy", busy_o, ph != 0);
      chk("done", done_o, ph == 4);
      chk("filter_mode", filter_mode_o, m_fm);
      chk("scale_shift", scale_shift_o, m_ss);
      chk("enable_block", enable_block_o, m_eb);
    end
  end

  task automatic cfg(input logic [1:0] f, input int q, input int k, input bit w,
                     input logic [2:0] s, input logic [CS-1:0] e);
    fm = f; qw = 4'(q); kit = IW'(k); woffs = w; ss = s; eb = e;
  endtask

  // pulse start for one cycle; returns the cycle number it is sampled in
  task automatic kick(output int c);
    c = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int dcy);
    dcy = -1;
    for (int i = 0; i < 60; i++) begin
      if (done_o) begin dcy = cyc; break; end
      @(negedge clk);
    end
    if (dcy < 0) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rnd) beat = 1'($urandom_range(0, 1));
      if (!m_act) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    beat = 1'b0;
  endtask

  initial begin
    int c, dcy, nwo, nd;
    int bq[8];
    int bexp[8];
    rst_n = 0; start = 0; abort = 0; beat = 0;
    cfg(FM3, 0, 0, 0, 3'd0, '0);
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_dw_wo", dw_weight_offset_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_clear", clear_o, 0);
    rst_n = 1;
    @(negedge clk);

    // T1: 1x1, qw=4, k=2, beat every cycle
    cfg(FM1, 4, 2, 0, 3'd5, 4'b1011); beat = 1;
    kick(c);
    bexp = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin @(negedge clk); bq[i] = int'(block_cnt_o); end
    for (int i = 0; i < 8; i++) chk("t1_block_seq", bq[i], bexp[i]);
    wait_done("t1", dcy);
    chk("t1_done_cycle", dcy - c, 13);
    chk("t1_sshift", scale_shift_o, 5);
    wait_idle(0);

    // T2: 3x3, qw=8, k=1, offset beat, random gaps
    cfg(FM3, 8, 1, 1, 3'd2, 4'b1111);
    kick(c);
    nwo = 0;
    for (int i = 0; i < 400 && m_act; i++) begin
      beat = 1'($urandom_range(0, 1));
      if (weight_offset_o && beat) begin
        nwo++;
        chk("t2_off_bc", block_cnt_o, 0);
      end
      @(negedge clk);
    end
    beat = 0;
    chk("t2_offset_beats", nwo, 1);
    wait_idle(0);

    // T3: qw=0, k=0 behaves as one beat
    cfg(FM3, 0, 0, 0, 3'd1, 4'b0001); beat = 1;
    kick(c);
    wait_done("t3", dcy);
    chk("t3_done_cycle", dcy - c, 6);
    wait_idle(0);

    // T4: abort on the 3rd MAC beat, then a clean tile
    cfg(FM3, 4, 2, 0, 3'd0, 4'b0110); beat = 1;
    kick(c);
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("t4_abort_clear", clear_o, 1);
    chk("t4_abort_busy", busy_o, 0);
    @(negedge clk);
    chk("t4_clear_once", clear_o, 0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin if (done_o) nd++; @(negedge clk); end
    chk("t4_no_done", nd, 0);
    cfg(FM1, 3, 1, 0, 3'd6, 4'b1001);
    kick(c);
    wait_done("t4b", dcy);
    chk("t4b_done_cycle", dcy - c, 8);
    wait_idle(0);

    // T5: start held high; a new tile begins right after each return to IDLE
    cfg(FM1, 2, 1, 0, 3'd3, 4'b0011); beat = 1;
    start = 1; nd = 0;
    for (int i = 0; i < 24; i++) begin @(negedge clk); if (done_o) nd++; end
    start = 0;
    chk("t5_done_count", nd, 3);
    wait_idle(0);

    // T6: reset in DRAIN
    cfg(FM3, 1, 1, 0, 3'd4, 4'b1100); beat = 1;
    kick(c);
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_enable", enable_o, 0);
    chk("t6_rst_clear", clear_o, 0);
    chk("t6_rst_fm", filter_mode_o, 0);
    rst_n = 1; beat = 0;
    @(negedge clk);

    // T7: DW mode with offset beat
    cfg(FMDW, 2, 1, 1, 3'd0, 4'b0101); beat = 1;
    kick(c);
    @(negedge clk);
    chk("t7_mac_dw_wo", dw_weight_offset_o, DW_EN ? 0 : 1);
    repeat (3) @(negedge clk);
    chk("t7_drain_inv", invalidate_o, DW_EN ? 1 : 0);
    chk("t7_drain_en", enable_o, 1);
    wait_idle(0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
